// File: rtl/bias_requant_stage.sv
`default_nettype none
// ============================================================================
// bias_requant_stage : bias add + int8 requantization pipeline fed by the bias ROM.
// Optional macro BIAS_REQUANT_RELU_EN adds cfg_relu_i (lower clamp at zero-point).
// Rev 1.0
// ============================================================================
module bias_requant_stage #(
    parameter int LANES   = 32,
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 8,
    parameter int MULT_W  = 32,
    parameter int SHIFT_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [11:0]              cfg_bias_base_i,
    input  logic signed [MULT_W-1:0] cfg_mult_i,
    input  logic [SHIFT_W-1:0]       cfg_shift_i,
    input  logic signed [OUT_W-1:0]  cfg_zp_out_i,
`ifdef BIAS_REQUANT_RELU_EN
    input  logic                     cfg_relu_i,
`endif
    input  logic                     acc_valid_i,
    output logic                     acc_ready_o,
    input  logic [LANES*ACC_W-1:0]   acc_data_i,
    input  logic [6:0]               acc_block_idx_i,
    input  logic                     acc_last_i,
    output logic [11:0]              bias_base_addr_o,
    output logic [6:0]               bias_block_idx_o,
    output logic                     bias_rd_en_o,
    input  logic [LANES*ACC_W-1:0]   bias_in_i,
    input  logic                     bias_valid_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [LANES*OUT_W-1:0]   out_data_o,
    output logic                     out_last_o,
    output logic                     busy_o
);

    localparam int PROD_W = ACC_W + MULT_W;
    localparam int Q_W    = PROD_W + 2;

    localparam logic signed [Q_W-1:0]    Q_MAX    = {{(Q_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [Q_W-1:0]    Q_MIN    = {{(Q_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [PROD_W:0]   PROD_ONE = {{PROD_W{1'b0}}, 1'b1};
    localparam logic [SHIFT_W-1:0]       SH_ONE   = {{(SHIFT_W-1){1'b0}}, 1'b1};

    logic                      a_valid_q, a_last_q, a_bias_have_q;
    logic [LANES*ACC_W-1:0]    a_acc_q, a_bias_q;
    logic                      b_valid_q, b_last_q;
    logic [LANES*ACC_W-1:0]    b_sum_q;
    logic                      c_valid_q, c_last_q;
    logic [LANES*PROD_W-1:0]   c_prod_q;
    logic                      d_valid_q, d_last_q;
    logic [LANES*OUT_W-1:0]    d_data_q;

    logic                      d_free, c_free, b_free, a_adv, hs;
    logic [LANES*ACC_W-1:0]    bias_use;
    logic [LANES*ACC_W-1:0]    sum_d;
    logic [LANES*PROD_W-1:0]   prod_d;
    logic [LANES*OUT_W-1:0]    out_d;
    logic                      relu_en;

`ifdef BIAS_REQUANT_RELU_EN
    assign relu_en = cfg_relu_i;
`else
    assign relu_en = 1'b0;
`endif

    assign d_free   = !d_valid_q || out_ready_i;
    assign c_free   = !c_valid_q || d_free;
    assign b_free   = !b_valid_q || c_free;
    // The ROM answers one cycle after the read; A leaves only with its bias in hand.
    assign a_adv    = a_valid_q && (a_bias_have_q || bias_valid_i) && b_free;
    assign acc_ready_o = !rst && (!a_valid_q || a_adv);
    assign hs       = acc_valid_i && acc_ready_o;
    assign bias_use = a_bias_have_q ? a_bias_q : bias_in_i;

    assign bias_rd_en_o     = hs;
    assign bias_block_idx_o = acc_block_idx_i;
    assign bias_base_addr_o = cfg_bias_base_i;

    assign out_valid_o = d_valid_q;
    assign out_data_o  = d_data_q;
    assign out_last_o  = d_last_q;
    assign busy_o      = a_valid_q || b_valid_q || c_valid_q || d_valid_q;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [ACC_W-1:0]  acc_l, bias_l, sum_l;
        logic signed [ACC_W:0]    sum_wide;
        logic signed [PROD_W-1:0] prod_l;
        logic signed [PROD_W:0]   prod_wide, rnd, r_l;
        logic signed [Q_W-1:0]    q_l, lo_l;
        logic [OUT_W-1:0]         lane_o;

        assign acc_l    = a_acc_q[gi*ACC_W +: ACC_W];
        assign bias_l   = bias_use[gi*ACC_W +: ACC_W];
        assign sum_wide = {acc_l[ACC_W-1], acc_l} + {bias_l[ACC_W-1], bias_l};

        always_comb begin
            sum_l = sum_wide[ACC_W-1:0];
            if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
                sum_l = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
        assign sum_d[gi*ACC_W +: ACC_W] = sum_l;

        assign prod_l = $signed(b_sum_q[gi*ACC_W +: ACC_W]) * cfg_mult_i;
        assign prod_d[gi*PROD_W +: PROD_W] = prod_l;

        // One guard bit keeps the rounding add from wrapping at the extreme product.
        assign prod_wide = {c_prod_q[(gi+1)*PROD_W-1], c_prod_q[gi*PROD_W +: PROD_W]};

        always_comb begin
            rnd = '0;
            if (cfg_shift_i != '0) begin
                rnd = PROD_ONE << (cfg_shift_i - SH_ONE);
            end
            r_l  = (prod_wide + rnd) >>> cfg_shift_i;
            q_l  = {r_l[PROD_W], r_l} + {{(Q_W-OUT_W){cfg_zp_out_i[OUT_W-1]}}, cfg_zp_out_i};
            lo_l = relu_en ? {{(Q_W-OUT_W){cfg_zp_out_i[OUT_W-1]}}, cfg_zp_out_i} : Q_MIN;
            if (q_l > Q_MAX) begin
                lane_o = Q_MAX[OUT_W-1:0];
            end else if (q_l < lo_l) begin
                lane_o = lo_l[OUT_W-1:0];
            end else begin
                lane_o = q_l[OUT_W-1:0];
            end
        end
        assign out_d[gi*OUT_W +: OUT_W] = lane_o;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid_q     <= 1'b0;
            a_last_q      <= 1'b0;
            a_bias_have_q <= 1'b0;
            a_acc_q       <= '0;
            a_bias_q      <= '0;
            b_valid_q     <= 1'b0;
            b_last_q      <= 1'b0;
            b_sum_q       <= '0;
            c_valid_q     <= 1'b0;
            c_last_q      <= 1'b0;
            c_prod_q      <= '0;
            d_valid_q     <= 1'b0;
            d_last_q      <= 1'b0;
            d_data_q      <= '0;
        end else begin
            if (hs) begin
                a_valid_q     <= 1'b1;
                a_acc_q       <= acc_data_i;
                a_last_q      <= acc_last_i;
                a_bias_have_q <= 1'b0;
            end else if (a_adv) begin
                a_valid_q     <= 1'b0;
                a_bias_have_q <= 1'b0;
            end else if (a_valid_q && !a_bias_have_q && bias_valid_i) begin
                a_bias_q      <= bias_in_i;
                a_bias_have_q <= 1'b1;
            end

            if (b_free) begin
                b_valid_q <= a_adv;
                if (a_adv) begin
                    b_sum_q  <= sum_d;
                    b_last_q <= a_last_q;
                end
            end

            if (c_free) begin
                c_valid_q <= b_valid_q;
                if (b_valid_q) begin
                    c_prod_q <= prod_d;
                    c_last_q <= b_last_q;
                end
            end

            if (d_free) begin
                d_valid_q <= c_valid_q;
                if (c_valid_q) begin
                    d_data_q <= out_d;
                    d_last_q <= c_last_q;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bias_requant_stage.sv
`default_nettype none
// ============================================================================
// tb_bias_requant_stage : directed cases plus randomized traffic against a reference model.
// Rev 1.0
// ============================================================================
module tb_bias_requant_stage;
    localparam int LANES = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [11:0]            cfg_bias_base = '0;
    logic signed [31:0]     cfg_mult = '0;
    logic [5:0]             cfg_shift = '0;
    logic signed [7:0]      cfg_zp = '0;
    logic                   cfg_relu = 1'b0;
    logic                   acc_valid = 1'b0;
    logic                   acc_ready;
    logic [LANES*32-1:0]    acc_data = '0;
    logic [6:0]             acc_block_idx = '0;
    logic                   acc_last = 1'b0;
    logic [11:0]            bias_base_addr;
    logic [6:0]             bias_block_idx;
    logic                   bias_rd_en;
    logic [LANES*32-1:0]    bias_in = '0;
    logic                   bias_valid = 1'b0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [LANES*8-1:0]     out_data;
    logic                   out_last;
    logic                   busy;

    always #5 clk = ~clk;

    bias_requant_stage #(.LANES(LANES), .ACC_W(32), .OUT_W(8), .MULT_W(32), .SHIFT_W(6)) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_bias_base_i  (cfg_bias_base),
        .cfg_mult_i       (cfg_mult),
        .cfg_shift_i      (cfg_shift),
        .cfg_zp_out_i     (cfg_zp),
`ifdef BIAS_REQUANT_RELU_EN
        .cfg_relu_i       (cfg_relu),
`endif
        .acc_valid_i      (acc_valid),
        .acc_ready_o      (acc_ready),
        .acc_data_i       (acc_data),
        .acc_block_idx_i  (acc_block_idx),
        .acc_last_i       (acc_last),
        .bias_base_addr_o (bias_base_addr),
        .bias_block_idx_o (bias_block_idx),
        .bias_rd_en_o     (bias_rd_en),
        .bias_in_i        (bias_in),
        .bias_valid_i     (bias_valid),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_data_o       (out_data),
        .out_last_o       (out_last),
        .busy_o           (busy)
    );

    // Bias ROM model: one-cycle read latency.
    logic [31:0] bias_mem [0:4095][0:LANES-1];
    always @(posedge clk) begin
        bias_valid <= bias_rd_en;
        if (bias_rd_en)
            for (int l = 0; l < LANES; l++)
                bias_in[l*32 +: 32] <= bias_mem[bias_base_addr + {5'b0, bias_block_idx}][l];
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: saturating add, exact product, round-half-up shift, zero-point, clamp.
    function automatic logic [7:0] ref_lane(input logic signed [31:0] acc, input logic signed [31:0] bias,
                                            input logic signed [31:0] mult, input int shift,
                                            input logic signed [7:0] zp, input bit relu);
        longint s;
        logic signed [127:0] sx, mx, p, rr, r, q, lo;
        s = longint'(acc) + longint'(bias);
        if (s > 64'sd2147483647)  s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        sx = s;
        mx = mult;
        p  = sx * mx;
        rr = (shift == 0) ? 128'sd0 : (128'sd1 <<< (shift - 1));
        r  = (p + rr) >>> shift;
        q  = r + 128'(zp);
        lo = relu ? 128'(zp) : -128'sd128;
        if (q > 128'sd127) q = 128'sd127;
        if (q < lo)        q = lo;
        return q[7:0];
    endfunction

    typedef struct { logic [LANES*8-1:0] data; logic last; } exp_t;
    exp_t exp_q[$];

    logic [LANES*8-1:0] hold_data;
    logic               hold_last;
    bit                 stalled = 0;
    bit                 saw_not_ready = 0;

    always @(negedge clk) begin
        if (rst) begin
            stalled = 0;
        end else begin
            if (stalled) begin
                check_eq("hold_valid", out_valid, 1'b1);
                check_eq("hold_data", {out_last, out_data}, {hold_last, hold_data});
            end
            if (acc_valid && acc_ready) begin
                exp_t e;
                logic [11:0] addr;
                addr = cfg_bias_base + {5'b0, acc_block_idx};
                check_eq("rd_en", bias_rd_en, 1'b1);
                check_eq("rd_idx", bias_block_idx, acc_block_idx);
                check_eq("rd_base", bias_base_addr, cfg_bias_base);
                for (int l = 0; l < LANES; l++)
                    e.data[l*8 +: 8] = ref_lane(acc_data[l*32 +: 32], bias_mem[addr][l], cfg_mult,
                                                int'(cfg_shift), cfg_zp, cfg_relu);
                e.last = acc_last;
                exp_q.push_back(e);
            end else begin
                check_eq("rd_idle", bias_rd_en, 1'b0);
            end
            if (acc_valid && !acc_ready) saw_not_ready = 1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", out_valid, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("out_data", out_data, e.data);
                    check_eq("out_last", out_last, e.last);
                end
            end
            stalled   = out_valid && !out_ready;
            hold_data = out_data;
            hold_last = out_last;
        end
    end

    bit rand_ready = 0;
    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Called just after a rising edge; returns just after the edge that took the vector.
    task automatic push_vec(input logic [LANES*32-1:0] data, input logic [6:0] idx, input bit last);
        int n = 0;
        acc_data      = data;
        acc_block_idx = idx;
        acc_last      = last;
        acc_valid     = 1'b1;
        forever begin
            @(negedge clk);
            if (acc_ready) break;
            n++;
            if (n > 200) begin
                check_eq("acc_ready_timeout", 1'b0, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
        acc_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rand_ready = 0;
        out_ready  = 1'b1;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic signed [31:0] acc, input logic signed [31:0] bias,
                           input logic signed [31:0] mult, input int shift, input logic signed [7:0] zp,
                           input logic [7:0] exp_lane);
        drain();
        cfg_bias_base = 12'h010;
        cfg_mult      = mult;
        cfg_shift     = shift[5:0];
        cfg_zp        = zp;
        for (int l = 0; l < LANES; l++) bias_mem[12'h012][l] = bias;
        push_vec({LANES{acc}}, 7'd2, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 3) check_eq({tag, "_early"}, out_valid, 1'b0);
        end
        check_eq({tag, "_valid_t4"}, out_valid, 1'b1);
        check_eq({tag, "_lane0"}, out_data[7:0], exp_lane);
        check_eq({tag, "_lane3"}, out_data[31:24], exp_lane);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [LANES*32-1:0] v;
        int cnt;
        for (int a = 0; a < 4096; a++)
            for (int l = 0; l < LANES; l++)
                bias_mem[a][l] = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom_range(0, 4000) - 2000);

        // Reset state with a pending request.
        acc_valid = 1'b1;
        #2;
        check_eq("rst_acc_ready", acc_ready, 1'b0);
        check_eq("rst_rd_en", bias_rd_en, 1'b0);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_last", out_last, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        acc_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        run_one("basic",   32'sd100,          -32'sd20,   32'sd1 * 3, 2,  -8'sd5, 8'd55);
        run_one("clamp_hi", 32'sd1000,         32'sd24,   32'sd1,     3,   8'sd0, 8'd127);
        run_one("neg_rnd", -32'sd10,           32'sd0,    32'sd1,     2,   8'sd0, 8'hFE);
        run_one("sat_sum",  32'sh7FFFFFF0,     32'sh100,  32'sd1,     31,  8'sd0, 8'd1);
`ifdef BIAS_REQUANT_RELU_EN
        drain();
        cfg_relu = 1'b1;
        run_one("relu_on", -32'sd140, 32'sd0, 32'sd1, 2, -8'sd5, 8'hFB);
        drain();
        cfg_relu = 1'b0;
        run_one("relu_off", -32'sd140, 32'sd0, 32'sd1, 2, -8'sd5, 8'hD8);
`endif

        // Burst of 8 with a downstream stall; per-vector bias rows.
        drain();
        cfg_bias_base = 12'h010; cfg_mult = 32'sd3; cfg_shift = 6'd2; cfg_zp = -8'sd5;
        for (int k = 0; k < 8; k++)
            for (int l = 0; l < LANES; l++) bias_mem[12'h010 + k][l] = k * 10 - l;
        saw_not_ready = 0;
        fork
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (7) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join_none
        for (int k = 0; k < 8; k++) begin
            for (int l = 0; l < LANES; l++) v[l*32 +: 32] = $urandom_range(0, 400) - 200;
            push_vec(v, 7'(k), k == 7);
        end
        drain();
        check_eq("burst_backpressure", saw_not_ready, 1'b1);

        // Reset with vectors in flight.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) push_vec({LANES{32'sd100}}, 7'(k), 1'b0);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_out_valid", out_valid, 1'b0);
        check_eq("midrst_out_data", out_data, 0);
        check_eq("midrst_busy", busy, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check_eq("midrst_no_out", cnt, 0);

        // Randomized batches; configuration changes only while idle.
        for (int b = 0; b < 8; b++) begin
            drain();
            cfg_bias_base = 12'($urandom);
            cfg_zp        = 8'($urandom);
            case (b % 4)
                0: begin cfg_mult = $urandom_range(1, 200);         cfg_shift = 6'($urandom_range(0, 12)); end
                1: begin cfg_mult = -$urandom_range(1, 200);        cfg_shift = 6'($urandom_range(0, 12)); end
                2: begin cfg_mult = $urandom;                       cfg_shift = 6'($urandom_range(20, 63)); end
                default: begin cfg_mult = 32'sd1;                   cfg_shift = 6'($urandom_range(0, 63)); end
            endcase
`ifdef BIAS_REQUANT_RELU_EN
            cfg_relu = 1'($urandom_range(0, 1));
`endif
            rand_ready = 1;
            for (int n = 0; n < 30; n++) begin
                int g;
                g = $urandom_range(0, 2);
                if (g > 0) begin
                    repeat (g) @(posedge clk);
                    #1;
                end
                for (int l = 0; l < LANES; l++)
                    v[l*32 +: 32] = ($urandom_range(0, 2) == 0) ? $urandom : ($urandom_range(0, 4000) - 2000);
                push_vec(v, 7'($urandom), n == 29);
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
